fir_xifu_result_sched: RTL
==========================

FIR_XIFU_RESULT_SCHED -- requirements
Module: fir_xifu_result_sched

Interface
REQ-001 SHALL have parameter ID_MAX, default 4, number of in-flight X-IF instruction IDs (power of 2).
REQ-002 SHALL have parameter ID_W, default $clog2(ID_MAX), ID field width.
REQ-003 SHALL have parameter DATA_W, default 32, result data width.
REQ-004 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port issue_valid_i  in  1  instruction accepted by ID stage this cycle.
REQ-007 SHALL have port issue_id_i  in  ID_W  ID of the issued instruction.
REQ-008 SHALL have port issue_rd_i  in  5  destination register of the issued instruction.
REQ-009 SHALL have port issue_we_i  in  1  instruction writes rd.
REQ-010 SHALL have port issue_ready_o  out  1  order queue not full.
REQ-011 SHALL have port commit_i  in  ID_MAX  per-ID committed flags from control stage.
REQ-012 SHALL have port kill_i  in  ID_MAX  per-ID killed flags from control stage.
REQ-013 SHALL have port done_i  in  ID_MAX  per-ID execution-complete flags from EX/WB.
REQ-014 SHALL have port data_i  in  ID_MAX*DATA_W  per-ID result data, ID k at bits [k*DATA_W +: DATA_W].
REQ-015 SHALL have port result_valid_o  out  1  X-IF result valid.
REQ-016 SHALL have port result_ready_i  in  1  X-IF result ready from core.
REQ-017 SHALL have port result_id_o / result_rd_o / result_we_o / result_data_o  out  ID_W / 5 / 1 / DATA_W  result payload.
REQ-018 SHALL have port clear_o  out  ID_MAX  one-hot, one-cycle pulse freeing an ID's status.

Function
REQ-019 SHALL keep an in-order queue of ID_MAX entries {id, rd, we} plus a per-ID pending vector; results SHALL leave strictly in issue order.
REQ-020 issue_ready_o SHALL equal ~full; it SHALL not depend on a same-cycle pop.
REQ-021 issue_valid_i & issue_ready_o & ~pending[issue_id_i] SHALL enqueue and set pending; an issue for an already-pending ID or while full SHALL be dropped with no state change.
REQ-022 FSM states: EMPTY, WAIT, RESULT; EMPTY->WAIT when queue non-empty.
REQ-023 In WAIT with kill_i[head] = 1: SHALL pulse clear_o[head], pop, clear pending, emit no result; next state WAIT if entries remain, else EMPTY (kill takes priority over commit/done).
REQ-024 In WAIT with commit_i[head] & done_i[head] & ~kill_i[head]: SHALL capture data_i slice of head into a result register and go to RESULT next cycle.
REQ-025 In RESULT: result_valid_o = 1, payload SHALL stay stable until result_ready_i; kill_i ignored.
REQ-026 RESULT with result_ready_i = 1: SHALL pulse clear_o[head], pop, clear pending in the same cycle; next state WAIT if entries remain, else EMPTY; a new result SHALL not be presented in the pop cycle.
REQ-027 Enqueue and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-028 Read/write pointers SHALL be ID_W bits plus wrap bit; full/empty from wrap-bit compare.

Reset
REQ-029 rst_i asserted SHALL immediately force: state EMPTY, queue empty, pending = 0, result_valid_o = 0, clear_o = 0, issue_ready_o = 1, payload outputs 0.
REQ-030 Reset mid-operation SHALL discard all queued IDs without clear_o pulses.

Configuration
REQ-031 Macro FIR_XIFU_RESULT_BYPASS_EN defined: in WAIT, when commit_i[head] & done_i[head] & ~kill_i[head], result_valid_o SHALL assert in the same cycle with result_data_o driven combinationally from data_i; ready in that cycle pops directly; otherwise state moves to RESULT with registered data.
REQ-032 Macro undefined: behaviour per REQ-024 (result_valid_o one cycle after commit&done), no combinational path from data_i/done_i/commit_i to result outputs.

Verification
REQ-033 Issue ID 1 (rd=5, we=1); commit_i[1], done_i[1], data 0xDEADBEEF at cycle N, ready=1 -> result_valid_o at N+1 (N with bypass), id 1, rd 5, data 0xDEADBEEF, clear_o=0b0010 in pop cycle.
REQ-034 Issue IDs 2 then 3; ID 3 done/committed first -> no result until ID 2 completes; results appear order 2, 3.
REQ-035 Issue ID 0, kill_i[0]=1 -> clear_o=0b0001 one cycle, result_valid_o never asserts, state EMPTY.
REQ-036 Issue 4 IDs without completion -> issue_ready_o=0; fifth issue dropped; after one pop issue_ready_o=1.
REQ-037 Result presented, hold result_ready_i=0 for 3 cycles while data_i changes -> result_data_o stable, single clear_o pulse on ready.
REQ-038 Assert rst_i with 3 queued IDs and result_valid_o=1 -> all outputs reset immediately, no clear_o pulse.

Source files
------------

// File: rtl/fir_xifu_result_sched_if.sv
// Bundle of issue, status and result signals between the X-IF core side and the
// result scheduler.
interface fir_xifu_result_sched_if #(
   parameter int unsigned ID_MAX = 4,
   parameter int unsigned ID_W   = $clog2(ID_MAX),
   parameter int unsigned DATA_W = 32
);
   logic                     issue_valid_i;
   logic [ID_W-1:0]          issue_id_i;
   logic [4:0]               issue_rd_i;
   logic                     issue_we_i;
   logic                     issue_ready_o;
   logic [ID_MAX-1:0]        commit_i;
   logic [ID_MAX-1:0]        kill_i;
   logic [ID_MAX-1:0]        done_i;
   logic [ID_MAX*DATA_W-1:0] data_i;
   logic                     result_valid_o;
   logic                     result_ready_i;
   logic [ID_W-1:0]          result_id_o;
   logic [4:0]               result_rd_o;
   logic                     result_we_o;
   logic [DATA_W-1:0]        result_data_o;
   logic [ID_MAX-1:0]        clear_o;

   modport slave (
      input  issue_valid_i, issue_id_i, issue_rd_i, issue_we_i,
      input  commit_i, kill_i, done_i, data_i, result_ready_i,
      output issue_ready_o, result_valid_o, result_id_o, result_rd_o, result_we_o,
      output result_data_o, clear_o
   );

   modport master (
      output issue_valid_i, issue_id_i, issue_rd_i, issue_we_i,
      output commit_i, kill_i, done_i, data_i, result_ready_i,
      input  issue_ready_o, result_valid_o, result_id_o, result_rd_o, result_we_o,
      input  result_data_o, clear_o
   );
endinterface

// File: rtl/fir_xifu_result_sched.sv
// In-order X-IF result scheduler: retires issued IDs strictly in issue order.
// Define FIR_XIFU_RESULT_BYPASS_EN to present a completing head result in the same cycle.
module fir_xifu_result_sched #(
   parameter int unsigned ID_MAX = 4,
   parameter int unsigned ID_W   = $clog2(ID_MAX),
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   fir_xifu_result_sched_if.slave xif
);

   typedef enum logic [1:0] {StEmpty, StWait, StResult} state_e;

   state_e              state_q, state_d;
   logic [ID_W:0]       wptr_q, rptr_q;
   logic [ID_W:0]       count;
   logic [ID_W-1:0]     q_id [ID_MAX];
   logic [4:0]          q_rd [ID_MAX];
   logic [ID_MAX-1:0]   q_we;
   logic [ID_MAX-1:0]   pending_q, pending_d;

   logic [ID_W-1:0]     res_id_q;
   logic [4:0]          res_rd_q;
   logic                res_we_q;
   logic [DATA_W-1:0]   res_data_q;

   logic [ID_W-1:0]     widx, ridx, head_id;
   logic [4:0]          head_rd;
   logic                head_we;
   logic [DATA_W-1:0]   head_data;
   logic                full, empty, push, pop, capture, last_entry, head_fire;
   logic                res_valid;
   logic [ID_MAX-1:0]   clear;
`ifdef FIR_XIFU_RESULT_BYPASS_EN
   logic                bypass;
`endif

   assign widx       = wptr_q[ID_W-1:0];
   assign ridx       = rptr_q[ID_W-1:0];
   assign count      = wptr_q - rptr_q;
   assign empty      = (wptr_q == rptr_q);
   assign full       = (wptr_q[ID_W] != rptr_q[ID_W]) && (widx == ridx);

   assign head_id    = q_id[ridx];
   assign head_rd    = q_rd[ridx];
   assign head_we    = q_we[ridx];
   assign head_data  = xif.data_i[int'(head_id)*DATA_W +: DATA_W];
   assign head_fire  = xif.commit_i[head_id] & xif.done_i[head_id];

   // An ID may only be in flight once; duplicates and issues while full are dropped.
   assign push       = xif.issue_valid_i & ~full & ~pending_q[xif.issue_id_i];
   assign last_entry = (count == (ID_W+1)'(1)) && !push;

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      capture   = 1'b0;
      res_valid = 1'b0;
      clear     = '0;
`ifdef FIR_XIFU_RESULT_BYPASS_EN
      bypass    = 1'b0;
`endif
      unique case (state_q)
         StEmpty: begin
            if (push || !empty) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (xif.kill_i[head_id]) begin
               pop = 1'b1;
            end else if (head_fire) begin
`ifdef FIR_XIFU_RESULT_BYPASS_EN
               res_valid = 1'b1;
               bypass    = 1'b1;
               if (xif.result_ready_i) begin
                  pop = 1'b1;
               end else begin
                  capture = 1'b1;
                  state_d = StResult;
               end
`else
               capture = 1'b1;
               state_d = StResult;
`endif
            end
         end
         StResult: begin
            res_valid = 1'b1;
            if (xif.result_ready_i) begin
               pop = 1'b1;
            end
         end
         default: state_d = StEmpty;
      endcase

      // A pop always frees the head ID; stay in WAIT while anything (incl. a same-cycle push) remains.
      if (pop) begin
         clear[head_id] = 1'b1;
         state_d        = last_entry ? StEmpty : StWait;
      end
   end

   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[head_id] = 1'b0;
      end
      if (push) begin
         pending_d[xif.issue_id_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StEmpty;
         wptr_q     <= '0;
         rptr_q     <= '0;
         pending_q  <= '0;
         q_we       <= '0;
         res_id_q   <= '0;
         res_rd_q   <= '0;
         res_we_q   <= 1'b0;
         res_data_q <= '0;
         for (int i = 0; i < ID_MAX; i++) begin
            q_id[i] <= '0;
            q_rd[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if (push) begin
            q_id[widx] <= xif.issue_id_i;
            q_rd[widx] <= xif.issue_rd_i;
            q_we[widx] <= xif.issue_we_i;
            wptr_q     <= wptr_q + (ID_W+1)'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + (ID_W+1)'(1);
         end
         if (capture) begin
            res_id_q   <= head_id;
            res_rd_q   <= head_rd;
            res_we_q   <= head_we;
            res_data_q <= head_data;
         end
      end
   end

   always_comb begin
      xif.result_id_o   = res_id_q;
      xif.result_rd_o   = res_rd_q;
      xif.result_we_o   = res_we_q;
      xif.result_data_o = res_data_q;
`ifdef FIR_XIFU_RESULT_BYPASS_EN
      if (bypass) begin
         xif.result_id_o   = head_id;
         xif.result_rd_o   = head_rd;
         xif.result_we_o   = head_we;
         xif.result_data_o = head_data;
      end
`endif
   end

   assign xif.result_valid_o = res_valid;
   assign xif.clear_o        = clear;
   assign xif.issue_ready_o  = ~full;

endmodule
